// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types and constants for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO_ADDR = '0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module   : regfile_rd_port
// Brief    : One combinational read port; same-cycle write bypass when
//            REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic                         run,
  input  logic                         re,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
  input  logic [(2**ADDR_W)-1:0]       busy,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_W-1:0]     waddr,
  input  logic [NUM_WR*DATA_W-1:0]     wdata,
  input  logic [NUM_WR-1:0]            set_vld,
  input  logic [NUM_WR*ADDR_W-1:0]     set_addr,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rd_busy
);

  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO_ADDR);

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  logic w_set_hit;
`else
  logic w_unused;
  assign w_unused = ^{we, waddr, wdata, set_vld, set_addr};
`endif

  always_comb begin
    rdata   = regs_flat[int'(raddr)*DATA_W +: DATA_W];
    rd_busy = busy[raddr];
`ifdef REGFILE_BYPASS_EN
    w_hit     = 1'b0;
    w_set_hit = 1'b0;
    // Ascending scan: the highest-index matching writer ends up selected.
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        w_hit = 1'b1;
        rdata = wdata[i*DATA_W +: DATA_W];
      end
      if (set_vld[i] && (set_addr[i*ADDR_W +: ADDR_W] == raddr)) begin
        w_set_hit = 1'b1;
      end
    end
    if (w_hit) begin
      rd_busy = w_set_hit;
    end
`endif
    if (!run || !re || (raddr == c_zero_addr)) begin
      rdata   = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with busy scoreboard and sequential
//            post-reset clear. Optional bypass: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        set_vld,
  input  logic [NUM_WR*ADDR_W-1:0] set_addr
);

  localparam int                DEPTH       = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO_ADDR);

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_cnt;
  logic                    r_ready;
  logic [DEPTH-1:0]        r_busy;
  logic [DATA_W-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]        w_busy_nxt;
  logic [DEPTH*DATA_W-1:0] w_regs_flat;
  logic                    w_run;

  assign ready = r_ready;
  assign w_run = (r_state == RUN);

  // Clears are applied first so a same-cycle set on the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i]) begin
        w_busy_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (set_vld[i] && (set_addr[i*ADDR_W +: ADDR_W] != c_zero_addr)) begin
        w_busy_nxt[set_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN:     r_busy  <= w_busy_nxt;
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the CLEAR walk zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_regs[r_cnt] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != c_zero_addr)) begin
            r_regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign w_regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
      ) u_rd_port (
        .run       (w_run),
        .re        (re[j]),
        .raddr     (raddr[j*ADDR_W +: ADDR_W]),
        .regs_flat (w_regs_flat),
        .busy      (r_busy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .set_vld   (set_vld),
        .set_addr  (set_addr),
        .rdata     (rdata[j*DATA_W +: DATA_W]),
        .rd_busy   (rd_busy[j])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the dual-issue MIPS core, replacing the single-issue 2R/1W file.
- Adds N read ports and M write ports, with deterministic write-conflict priority.
- Adds a per-register busy scoreboard for issue-stage hazard detection.
- Clears registers sequentially after reset, one register per cycle, instead of with a wide parallel reset.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports; higher index has higher priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high once the post-reset clear has finished.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  packed write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  packed write data.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  packed read addresses.
- rdata  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  high when the addressed register has a pending producer.
- set_vld  in  NUM_WR  scoreboard set request: an instruction issued with a destination.
- set_addr  in  NUM_WR*ADDR_W  destination register to mark busy.

Behaviour:
- States: CLEAR, RUN.
- rst=1 at any clock edge, including mid-clear or mid-run:
  - next state CLEAR, clear counter = 0, all busy bits = 0, ready = 0.
- CLEAR:
  - Writes zero to the register at the counter each cycle, then increments the counter.
  - When the counter reaches 2**ADDR_W-1, that register is written and the next state is RUN.
  - Total time: 2**ADDR_W cycles after rst deasserts (32 with defaults). ready rises on the first RUN cycle.
  - we and set_vld are ignored. rdata = 0 and rd_busy = 0 on all ports.
- RUN, write:
  - On the clock edge, for each port i with we[i]=1 and waddr!=0: regs[waddr] <= wdata.
  - If several ports target the same address, the highest index wins.
- Register 0:
  - Always reads 0, is never written, and is never busy.
  - set_addr=0 is ignored.
- RUN, scoreboard:
  - set_vld[i] with set_addr!=0 sets busy[set_addr] on the clock edge.
  - A write with we[i]=1 clears busy[waddr] on the clock edge.
  - If a set and a clear target the same register in one cycle, the set wins (a new producer supersedes the old one).
- RUN, read port j:
  - raddr=0 or re[j]=0: rdata=0, rd_busy=0.
  - Otherwise: rdata = regs[raddr], rd_busy = busy[raddr].
  - Read latency is zero.
  - A same-cycle write becomes visible in rdata on the next cycle unless bypass is compiled in (see Optional Feature).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port compares raddr against every write port in the same cycle.
  - On a match with we=1 and raddr!=0, rdata returns the wdata of the highest-index matching write port.
  - rd_busy is forced to 0 for that read, unless a same-cycle set_vld targets the same address; the set/clear priority above still governs.
- Undefined:
  - No bypass; reads return stored register contents only.
  - rd_busy reflects the registered busy bits only.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum {CLEAR, RUN};
  - default constants REG_DATA_W=32 and REG_ADDR_W=5;
  - the zero-register address constant.
- Natural sub-module: regfile_rd_port, containing one read mux plus the bypass compare and priority select.
  - It is instantiated NUM_RD times from a generate loop.
  - Storage, scoreboard and the clear state machine stay in regfile_mp.

Test Plan:
- Reset/clear: pulse rst 1 cycle, then read r7 each cycle -> ready=0 for exactly 32 cycles, rdata=0 throughout, ready=1 on cycle 33. Assert rst again at clear cycle 10 -> counter restarts and ready rises 32 cycles after the new deassert.
- Basic write/read: we[0]=1, waddr=3, wdata=0xDEADBEEF; next cycle read port 2 raddr=3 -> rdata=0xDEADBEEF. Write r0=0x1234 -> any read of r0 returns 0.
- Write conflict: we=2'b11, both waddr=5, wdata0=0x11, wdata1=0x22 -> r5 reads 0x22 next cycle.
- Scoreboard: set_vld[0], set_addr=9 -> rd_busy=1 for raddr=9 next cycle. Write r9 -> busy cleared on the following cycle. Same-cycle set r9 and write r9 -> busy stays 1.
- Bypass (REGFILE_BYPASS_EN):
  - Write r4=0xCAFE while reading r4 in the same cycle -> rdata=0xCAFE, rd_busy=0.
  - Without the macro, the same stimulus -> rdata = old value, rd_busy = prior busy bit.
- Ignored-during-clear: during CLEAR, we[1]=1 to r6 with 0x55, set_vld to r6 -> after ready, r6 reads 0 and is not busy.
